conv_result_streamer: RTL
=========================

// Module: conv_result_streamer
// PURPOSE
//   Reader/sequencer for the 4x4-input / 3x3-filter systolic convolution engines.
//   It pulses the engine's active-high rst, waits a fixed compute latency, and captures the 2x2 result (o00..o11).
//   It then streams the four results out one byte per beat over a valid/ready interface.
//   It sits between any of the one/two/three-by systolic engines and the downstream result consumer.
// PARAMETERS
//   DATA_W   8   width of each result word and of m_data
//   LATENCY  12  cycles from engine rst deassertion until o00..o11 are valid; must be >= 1
//   CNT_W    5   latency counter width; 2**CNT_W must be > LATENCY
// PORTS
//   clk      in   1       single clock, rising edge
//   rst      in   1       asynchronous, active-low reset
//   start    in   1       request one convolution run; sampled in IDLE only
//   clr      in   1       synchronous clear of the sticky overrun flag
//   o00      in   DATA_W  engine result row 0 col 0
//   o01      in   DATA_W  engine result row 0 col 1
//   o10      in   DATA_W  engine result row 1 col 0
//   o11      in   DATA_W  engine result row 1 col 1
//   eng_rst  out  1       active-high reset driven to the systolic engine
//   m_valid  out  1       stream beat valid
//   m_data   out  DATA_W  stream payload
//   m_idx    out  2       result index of the beat: 0=o00, 1=o01, 2=o10, 3=o11
//   m_last   out  1       high on the idx-3 beat
//   m_ready  in   1       downstream accepts the beat
//   busy     out  1       high whenever state != IDLE
//   overrun  out  1       sticky flag: a start arrived while busy
// BEHAVIOUR
//   - All outputs are registered. While rst=0 (asynchronous): state=IDLE, eng_rst=1, m_valid=0,
//     m_data=0, m_idx=0, m_last=0, busy=0, overrun=0, capture buffer=0, counter=0.
//   - FSM states: IDLE -> KICK -> WAIT -> SEND -> IDLE.
//   - IDLE: eng_rst=1. start=1 sampled at edge k -> KICK.
//   - KICK: lasts exactly 1 cycle (edge k to edge k+1). eng_rst stays 1 and busy=1. Next state WAIT, counter=0.
//   - WAIT: eng_rst=0, and the counter increments once per cycle.
//     At the edge where counter==LATENCY-1, o00..o11 are captured into a 4-entry buffer.
//     On that same edge: state -> SEND, eng_rst -> 1, m_valid -> 1, m_idx -> 0, m_data -> buf[0].
//   - Timing: eng_rst is low for exactly LATENCY cycles. m_valid rises LATENCY+1 cycles after the start edge.
//   - SEND: a beat transfers on a rising edge with m_valid=1 and m_ready=1.
//     On each transfer m_idx increments and m_data is loaded from the next buffer entry.
//     Order is fixed: o00, o01, o10, o11. m_last=1 exactly when m_idx==3.
//     While m_valid=1 and m_ready=0, m_data, m_idx and m_last hold stable.
//   - Transfer of the idx-3 beat -> IDLE: m_valid=0, m_last=0, busy=0 on that edge.
//     m_idx returns to 0 and m_data keeps its last value.
//   - Engine outputs changing after the capture edge have no effect on the stream.
//   - start while not IDLE (KICK/WAIT/SEND) is ignored and sets overrun=1.
//     This includes a start coincident with the final transfer. No request is queued.
//   - overrun clears only on clr=1 or reset. If clr and a new overrun occur on the same edge, overrun=1 wins.
//   - m_ready is ignored outside SEND. No combinational path exists from m_ready to m_valid.
//   - Reset mid-operation: the FSM aborts immediately and the partial stream is dropped.
//     The next start produces a full 4-beat stream starting from idx 0.
// TESTING
//   1. Assert rst=0 mid-clock: all outputs take their reset values at once, with eng_rst=1, m_valid=0, overrun=0.
//   2. Hold o00=0x2F, o01=0x19, o10=0x23, o11=0x2A with m_ready=1 and pulse start:
//      eng_rst low for exactly 12 cycles; m_valid rises 13 cycles after the start edge;
//      beats 2F, 19, 23, 2A with idx 0..3 on consecutive cycles; m_last on beat 4; busy=0 afterwards.
//   3. Repeat 2 with m_ready toggling 0,1,0,1...: each beat is held stable while m_ready=0.
//      Exactly 4 transfers occur, in order 2F, 19, 23, 2A.
//   4. Repeat 2, but change o00 to 0xFF and o11 to 0x00 one cycle after m_valid rises:
//      the stream still carries 2F, 19, 23, 2A.
//   5. Pulse start during WAIT and again on the final-transfer edge: no extra run occurs and overrun=1.
//      Pulse clr: overrun=0. Then start: a normal run follows.
//   6. Assert rst=0 after the first beat transfers in SEND: m_valid drops asynchronously.
//      Release rst and pulse start: a full fresh 4-beat stream with idx 0..3.

Source files
------------

// File: rtl/conv_result_streamer_if.sv
// Result stream carried from the convolution result streamer to its consumer.
// Holds one result byte per beat, the beat's result index and a last-beat marker.
interface conv_result_streamer_if #(
    parameter int DATA_W = 8
);
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [1:0]        m_idx;
    logic              m_last;
    logic              m_ready;

    modport master (
        output m_valid,
        output m_data,
        output m_idx,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_idx,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/conv_result_streamer.sv
// Reader/sequencer for the 4x4-input / 3x3-filter systolic convolution engines.
// It releases the engine reset, waits a fixed compute latency and captures the 2x2 result.
// It then streams o00, o01, o10, o11 one byte per beat over valid/ready.
module conv_result_streamer #(
    parameter int DATA_W  = 8,
    parameter int LATENCY = 12,
    parameter int CNT_W   = 5
) (
    input  logic                     clk,
    input  logic                     rst,      // asynchronous, active-low
    input  logic                     start,
    input  logic                     clr,
    input  logic [DATA_W-1:0]        o00,
    input  logic [DATA_W-1:0]        o01,
    input  logic [DATA_W-1:0]        o10,
    input  logic [DATA_W-1:0]        o11,
    output logic                     eng_rst,
    output logic                     busy,
    output logic                     overrun,
    conv_result_streamer_if.master   m_if
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_KICK = 2'd1,
        S_WAIT = 2'd2,
        S_SEND = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] buf_q [4];
    logic              eng_rst_q;
    logic              busy_q;
    logic              overrun_q;
    logic              m_valid_q;
    logic [DATA_W-1:0] m_data_q;
    logic [1:0]        m_idx_q;
    logic              m_last_q;

    // Sequencer: reset pulse, latency count, result capture and beat streaming, all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= {DATA_W{1'b0}};
            end
            eng_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= {DATA_W{1'b0}};
            m_idx_q   <= 2'd0;
            m_last_q  <= 1'b0;
        end else begin
            // A start seen outside IDLE is dropped but flagged; a new overrun beats a same-edge clear.
            if (start && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end else if (clr) begin
                overrun_q <= 1'b0;
            end else begin
                overrun_q <= overrun_q;
            end

            case (state_q)
                S_IDLE: begin
                    eng_rst_q <= 1'b1;
                    if (start) begin
                        state_q <= S_KICK;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_KICK: begin
                    // Engine is held in reset for this one cycle, then released for the count.
                    state_q   <= S_WAIT;
                    cnt_q     <= {CNT_W{1'b0}};
                    eng_rst_q <= 1'b0;
                end
                S_WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        // Snapshot the engine results so later changes cannot reach the stream.
                        buf_q[0]  <= o00;
                        buf_q[1]  <= o01;
                        buf_q[2]  <= o10;
                        buf_q[3]  <= o11;
                        state_q   <= S_SEND;
                        eng_rst_q <= 1'b1;
                        m_valid_q <= 1'b1;
                        m_idx_q   <= 2'd0;
                        m_data_q  <= o00;
                        m_last_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_SEND: begin
                    if (m_if.m_ready) begin
                        if (m_idx_q == 2'd3) begin
                            // Final beat accepted: m_data keeps its last value.
                            state_q   <= S_IDLE;
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            m_idx_q   <= 2'd0;
                            busy_q    <= 1'b0;
                        end else begin
                            m_idx_q  <= m_idx_q + 2'd1;
                            m_data_q <= buf_q[m_idx_q + 2'd1];
                            m_last_q <= (m_idx_q == 2'd2);
                        end
                    end else begin
                        m_idx_q <= m_idx_q;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    eng_rst_q <= 1'b1;
                    busy_q    <= 1'b0;
                    m_valid_q <= 1'b0;
                    m_last_q  <= 1'b0;
                    m_idx_q   <= 2'd0;
                end
            endcase
        end
    end

    assign eng_rst        = eng_rst_q;
    assign busy           = busy_q;
    assign overrun        = overrun_q;
    assign m_if.m_valid   = m_valid_q;
    assign m_if.m_data    = m_data_q;
    assign m_if.m_idx     = m_idx_q;
    assign m_if.m_last    = m_last_q;

endmodule
